// File: rtl/path_tracer.sv
// Animated "U" path tracer: a square sweeps a U-shaped path on a small raster,
// painting its trail, with a second phase that overlays the trail in another colour.
module path_tracer #(
  parameter int unsigned SCREEN_W = 96,
  parameter int unsigned SCREEN_H = 64,
  parameter int unsigned SQ       = 15,
  parameter int unsigned MIN_X    = 6,
  parameter int unsigned MAX_X    = 90,
  parameter int unsigned MIN_Y    = 4,
  parameter int unsigned MAX_Y    = 60,
  parameter int unsigned TICK_DIV = 1666667,
  parameter int unsigned STEP_A   = 1,
  parameter int unsigned STEP_B   = 2,
  parameter int unsigned DWELL    = 45,
  parameter logic [15:0] COL_A    = 16'h07E0,
  parameter logic [15:0] COL_B    = 16'hF800,
  parameter logic [15:0] COL_BG   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_phase2,
  input  logic        pause,
  input  logic [12:0] pixel_index,
  output logic [15:0] colour,
  output logic        busy
);

  localparam int unsigned XE = MAX_X - SQ;
  localparam int unsigned YE = MAX_Y - SQ;
  // Coordinates must hold limit + step so the saturation compare cannot wrap.
  localparam int unsigned CW = $clog2(MAX_X + MAX_Y + STEP_A + STEP_B + 1);
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned PW = 13;

  localparam logic [CW-1:0] C_MINX = CW'(MIN_X);
  localparam logic [CW-1:0] C_MINY = CW'(MIN_Y);
  localparam logic [CW-1:0] C_XE   = CW'(XE);
  localparam logic [CW-1:0] C_YE   = CW'(YE);
  localparam logic [CW-1:0] C_SA   = CW'(STEP_A);
  localparam logic [CW-1:0] C_SB   = CW'(STEP_B);

  localparam logic [PW-1:0] P_MINX = PW'(MIN_X);
  localparam logic [PW-1:0] P_MAXX = PW'(MAX_X);
  localparam logic [PW-1:0] P_MINY = PW'(MIN_Y);
  localparam logic [PW-1:0] P_MAXY = PW'(MAX_Y);
  localparam logic [PW-1:0] P_XE   = PW'(XE);
  localparam logic [PW-1:0] P_YE   = PW'(YE);
  localparam logic [PW-1:0] P_SQ   = PW'(SQ);
  localparam logic [PW-1:0] P_W    = PW'(SCREEN_W);
  localparam logic [PW-1:0] P_NPIX = PW'(SCREEN_W * SCREEN_H);

  typedef enum logic [3:0] {
    IDLE, A_RIGHT, A_DW1, A_DOWN, A_DW2, A_LEFT, A_DW3, HOLD,
    B_RIGHT, B_UP, B_LEFT, B_DW
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] x, x_n, y, y_n;
  logic [DW-1:0] dwell, dwell_n;
  logic [TW-1:0] tick_cnt;
  logic          tick_c;
  logic [2:0]    start_sync, ph2_sync;
  logic          start_edge_c, ph2_edge_c;
  logic          start_lat, ph2_lat;
  logic          dwell_done_c;

  function automatic logic [CW-1:0] step_up(input logic [CW-1:0] v, input logic [CW-1:0] s,
                                            input logic [CW-1:0] lim);
    return (v + s >= lim) ? lim : v + s;
  endfunction

  function automatic logic [CW-1:0] step_dn(input logic [CW-1:0] v, input logic [CW-1:0] s,
                                            input logic [CW-1:0] lim);
    return (v <= lim + s) ? lim : v - s;
  endfunction

  function automatic logic in_box(input logic [PW-1:0] c, input logic [PW-1:0] r,
                                  input logic [PW-1:0] x0, input logic [PW-1:0] x1,
                                  input logic [PW-1:0] y0, input logic [PW-1:0] y1);
    return (c >= x0) && (c < x1) && (r >= y0) && (r < y1);
  endfunction

  assign tick_c       = !pause && (tick_cnt == TW'(TICK_DIV - 1));
  assign start_edge_c = start_sync[1] & ~start_sync[2];
  assign ph2_edge_c   = ph2_sync[1] & ~ph2_sync[2];
  assign dwell_done_c = (dwell == DW'(DWELL - 1));

  // Movement tick divider, frozen while paused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_cnt <= '0;
    else if (!pause) tick_cnt <= tick_c ? '0 : tick_cnt + 1'b1;
  end

  // Button synchronisers, edge detect, and edge latches held until the next tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_sync <= '0;
      ph2_sync   <= '0;
      start_lat  <= 1'b0;
      ph2_lat    <= 1'b0;
    end else begin
      start_sync <= {start_sync[1:0], btn_start};
      ph2_sync   <= {ph2_sync[1:0], btn_phase2};
      start_lat  <= tick_c ? start_edge_c : (start_lat | start_edge_c);
      ph2_lat    <= tick_c ? ph2_edge_c : (ph2_lat | ph2_edge_c);
    end
  end

  // Path state, square position, dwell counter and busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      x     <= C_MINX;
      y     <= C_MINY;
      dwell <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      x     <= x_n;
      y     <= y_n;
      dwell <= dwell_n;
      busy  <= (state_n != IDLE) && (state_n != HOLD);
    end
  end

  // Next-state logic: everything advances only on a tick.
  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    dwell_n = dwell;
    if (tick_c) begin
      case (state)
        IDLE: if (start_lat) begin
          x_n = C_MINX; y_n = C_MINY; state_n = A_RIGHT;
        end
        A_RIGHT: if (x == C_XE) state_n = A_DW1; else x_n = step_up(x, C_SA, C_XE);
        A_DOWN:  if (y == C_YE) state_n = A_DW2; else y_n = step_up(y, C_SA, C_YE);
        A_LEFT:  if (x == C_MINX) state_n = A_DW3; else x_n = step_dn(x, C_SA, C_MINX);
        A_DW1, A_DW2, A_DW3, B_DW: begin
          if (dwell_done_c) begin
            dwell_n = '0;
            case (state)
              A_DW1:   state_n = A_DOWN;
              A_DW2:   state_n = A_LEFT;
              A_DW3:   state_n = HOLD;
              default: begin state_n = IDLE; x_n = C_MINX; y_n = C_MINY; end
            endcase
          end else begin
            dwell_n = dwell + 1'b1;
          end
        end
        HOLD: if (ph2_lat) begin
          x_n = C_MINX; y_n = C_YE; state_n = B_RIGHT;
        end
        B_RIGHT: if (x == C_XE) state_n = B_UP; else x_n = step_up(x, C_SB, C_XE);
        B_UP:    if (y == C_MINY) state_n = B_LEFT; else y_n = step_dn(y, C_SB, C_MINY);
        B_LEFT:  if (x == C_MINX) state_n = B_DW; else x_n = step_dn(x, C_SB, C_MINX);
        default: state_n = IDLE;
      endcase
    end
  end

  logic [PW-1:0] col_c, row_c, xp_c, yp_c;
  logic          top_c, right_c, bot_c, u_c, paint_a_c, paint_b_c;
  logic [15:0]   colour_n;

  assign col_c   = pixel_index % P_W;
  assign row_c   = pixel_index / P_W;
  assign xp_c    = PW'(x);
  assign yp_c    = PW'(y);
  assign top_c   = in_box(col_c, row_c, P_MINX, P_MAXX, P_MINY, P_MINY + P_SQ);
  assign right_c = in_box(col_c, row_c, P_XE, P_MAXX, P_MINY, P_MAXY);
  assign bot_c   = in_box(col_c, row_c, P_MINX, P_MAXX, P_YE, P_MAXY);
  assign u_c     = top_c | right_c | bot_c;

  // Per-state paint masks; phase B colour overrides phase A colour.
  always_comb begin
    paint_a_c = 1'b0;
    paint_b_c = 1'b0;
    case (state)
      IDLE:           paint_a_c = in_box(col_c, row_c, P_MINX, P_MINX + P_SQ, P_MINY, P_MINY + P_SQ);
      A_RIGHT, A_DW1: paint_a_c = in_box(col_c, row_c, P_MINX, xp_c + P_SQ, P_MINY, P_MINY + P_SQ);
      A_DOWN, A_DW2:  paint_a_c = top_c | in_box(col_c, row_c, P_XE, P_MAXX, P_MINY, yp_c + P_SQ);
      A_LEFT, A_DW3:  paint_a_c = top_c | right_c | in_box(col_c, row_c, xp_c, P_MAXX, P_YE, P_MAXY);
      HOLD:           paint_a_c = u_c;
      B_RIGHT: begin
        paint_a_c = u_c;
        paint_b_c = in_box(col_c, row_c, P_MINX, xp_c + P_SQ, P_YE, P_MAXY);
      end
      B_UP: begin
        paint_a_c = u_c;
        paint_b_c = bot_c | in_box(col_c, row_c, P_XE, P_MAXX, yp_c, P_MAXY);
      end
      B_LEFT: begin
        paint_a_c = u_c;
        paint_b_c = bot_c | right_c | in_box(col_c, row_c, xp_c, P_MAXX, P_MINY, P_MINY + P_SQ);
      end
      B_DW: begin
        paint_a_c = u_c;
        paint_b_c = u_c;
      end
      default: paint_a_c = 1'b0;
    endcase
    if (pixel_index >= P_NPIX) colour_n = COL_BG;
    else if (paint_b_c)        colour_n = COL_B;
    else if (paint_a_c)        colour_n = COL_A;
    else                       colour_n = COL_BG;
  end

  // Pixel colour register: one clock of latency from pixel_index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) colour <= COL_BG;
    else     colour <= colour_n;
  end

endmodule
